// File: rtl/dot_product_ram_mac_if.sv
// Bus between the dot-product sequencer and its environment: RAM read
// addresses/data, the start/len request and the done/result report.
interface dot_product_ram_mac_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
);
  logic                         start;
  logic [ADDR_WIDTH:0]          len;
  logic [ADDR_WIDTH-1:0]        addr_a;
  logic [ADDR_WIDTH-1:0]        addr_b;
  logic signed [DATA_WIDTH-1:0] dout_a;
  logic signed [DATA_WIDTH-1:0] dout_b;
  logic                         busy;
  logic                         done;
  logic signed [ACC_WIDTH-1:0]  result;

  modport master (
    output start, len, dout_a, dout_b,
    input  addr_a, addr_b, busy, done, result
  );

  modport slave (
    input  start, len, dout_a, dout_b,
    output addr_a, addr_b, busy, done, result
  );
endinterface

// File: rtl/dot_product_ram_mac.sv
// Read sequencer + MAC behind two synchronous-read RAMs: walks addresses
// 0..len-1, absorbs the one-cycle read latency and accumulates a signed dot product.
module dot_product_ram_mac #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  dot_product_ram_mac_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                      r_state;
  logic [ADDR_WIDTH:0]         r_cnt;
  logic [ADDR_WIDTH:0]         r_len;
  logic                        r_vld_p1;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] r_result;
  logic signed [ACC_WIDTH-1:0] w_acc_next;
  logic                        w_last;

  // Product is sign-extended to the accumulator width; the sum wraps, never saturates.
  function automatic logic signed [ACC_WIDTH-1:0] mac_wrap(
    input logic signed [ACC_WIDTH-1:0]  acc,
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    ext;
    prod = a * b;
    ext  = ACC_WIDTH'(prod);
    return acc + ext;
  endfunction

  assign w_acc_next = r_vld_p1 ? mac_wrap(r_acc, bus.dout_a, bus.dout_b) : r_acc;
  assign w_last     = (r_cnt == r_len - (ADDR_WIDTH+1)'(1));

  assign bus.addr_a = (r_state == S_READ) ? r_cnt[ADDR_WIDTH-1:0] : '0;
  assign bus.addr_b = (r_state == S_READ) ? r_cnt[ADDR_WIDTH-1:0] : '0;
  assign bus.busy   = (r_state == S_READ) || (r_state == S_DRAIN);
  assign bus.done   = (r_state == S_DONE);
  assign bus.result = r_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_len    <= '0;
      r_vld_p1 <= 1'b0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      // p1: RAM data for the address issued last cycle is on dout_a/dout_b
      r_vld_p1 <= (r_state == S_READ);
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            if (bus.len != '0) begin
              r_state <= S_READ;
              r_len   <= bus.len;
              r_cnt   <= '0;
              r_acc   <= '0;
            end else begin
              r_state  <= S_DONE;
              r_result <= '0;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_READ: begin
          r_cnt <= r_cnt + (ADDR_WIDTH+1)'(1);
          r_acc <= w_acc_next;
          if (w_last) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          r_acc    <= w_acc_next;
          r_result <= w_acc_next;
          r_state  <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
